// File: rtl/sel_range_pkg.sv
// Shared types and helpers for the bounds-checked part-select engine.
package sel_range_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Lowest source bit of the field; for the down direction the field ends at index.
  function automatic int calc_lo(input int index, input dir_e dir, input int w_eff);
    return (dir == DIR_DOWN) ? (index - w_eff + 1) : index;
  endfunction

  // True when src addresses a real bit of a data_w-bit word.
  function automatic logic range_ok(input int src, input int data_w);
    return (src >= 0) && (src < data_w);
  endfunction

endpackage

// File: rtl/sel_range_unit_bit.sv
// One result bit of the part-select: picks data[lo+J] or the fill value and flags it.
module sel_range_bit
  import sel_range_pkg::*;
#(
  parameter int   DATA_W = 44,
  parameter int   IDX_W  = 7,
  parameter int   WW     = 4,
  parameter int   J      = 0,
  parameter logic FILL   = 1'b0
) (
  input  logic [DATA_W-1:0]      data,
  input  logic signed [IDX_W+1:0] lo,
  input  logic [WW-1:0]          w_eff,
  output logic                   res,
  output logic                   oob
);

  localparam int SW = $clog2(DATA_W);

  int            src;
  logic [SW-1:0] sidx;

  // Bits beyond the field width are zero; in-field bits outside the word take FILL.
  always_comb begin
    src  = int'(lo) + J;
    sidx = SW'(src);
    res  = 1'b0;
    oob  = 1'b0;
    if (J < int'(w_eff)) begin
      if (range_ok(src, DATA_W)) begin
        res = data[sidx];
      end else begin
        res = FILL;
        oob = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sel_range_unit.sv
// Two-stage runtime part-select with per-bit out-of-range flags and a saturating OOB counter.
module sel_range_unit
  import sel_range_pkg::*;
#(
  parameter int   DATA_W = 44,
  parameter int   OUT_W  = 8,
  parameter int   IDX_W  = 7,
  parameter logic FILL   = 1'b0,
  parameter int   CNT_W  = 8,
  localparam int  WW     = $clog2(OUT_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_index,
  input  logic              in_dir,
  input  logic [WW-1:0]     in_width,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [OUT_W-1:0]  out_oob_mask,
  output logic              out_oob,
  input  logic              clr_count,
  output logic [CNT_W-1:0]  oob_count
);

  localparam int LW = IDX_W + 2;

  logic                 adv;
  logic [WW-1:0]        w_eff_next;
  logic signed [LW-1:0] lo_next;

  logic                 s1_valid;
  logic [DATA_W-1:0]    s1_data;
  logic signed [LW-1:0] s1_lo;
  logic [WW-1:0]        s1_weff;

  logic [OUT_W-1:0]     bit_res;
  logic [OUT_W-1:0]     bit_oob;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Clamp width and compute the low source index with two guard bits so it cannot wrap.
  always_comb begin
    w_eff_next = (in_width > WW'(OUT_W)) ? WW'(OUT_W) : in_width;
    lo_next    = LW'(calc_lo(int'($signed(in_index)), dir_e'(in_dir), int'(w_eff_next)));
  end

  for (genvar j = 0; j < OUT_W; j++) begin : g_bit
    sel_range_bit #(
      .DATA_W(DATA_W),
      .IDX_W (IDX_W),
      .WW    (WW),
      .J     (j),
      .FILL  (FILL)
    ) u_bit (
      .data (s1_data),
      .lo   (s1_lo),
      .w_eff(s1_weff),
      .res  (bit_res[j]),
      .oob  (bit_oob[j])
    );
  end

  // Both stages move together on adv; bubbles advance with valid cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid     <= 1'b0;
      s1_data      <= '0;
      s1_lo        <= '0;
      s1_weff      <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_oob_mask <= '0;
      out_oob      <= 1'b0;
    end else if (adv) begin
      s1_valid     <= in_valid;
      s1_data      <= in_data;
      s1_lo        <= lo_next;
      s1_weff      <= w_eff_next;
      out_valid    <= s1_valid;
      out_data     <= bit_res;
      out_oob_mask <= bit_oob;
      out_oob      <= |bit_oob;
    end
  end

  // Count delivered OOB results, saturating; clear has priority over an increment.
  always_ff @(posedge clk) begin
    if (reset || clr_count) begin
      oob_count <= '0;
    end else if (out_valid && out_ready && out_oob && (oob_count != '1)) begin
      oob_count <= oob_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_sel_range_unit.sv
// Scoreboard bench for sel_range_unit: directed vectors, stall, saturation, clear and reset.
module tb_sel_range_unit;

  localparam int DATA_W = 44;
  localparam int OUT_W  = 8;
  localparam int IDX_W  = 7;
  localparam int WW     = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [IDX_W-1:0]  in_index = '0;
  logic              in_dir = 1'b0;
  logic [WW-1:0]     in_width = '0;
  logic              out_ready = 1'b1;
  logic              clr_count = 1'b0;

  logic              in_ready, out_valid, out_oob;
  logic [OUT_W-1:0]  out_data, out_oob_mask;
  logic [7:0]        oob_count;

  logic              in_ready2, out_valid2, out_oob2;
  logic [OUT_W-1:0]  out_data2, out_oob_mask2;
  logic [1:0]        oob_count2;

  sel_range_unit #(.DATA_W(DATA_W), .OUT_W(OUT_W), .IDX_W(IDX_W), .FILL(1'b0), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_index(in_index), .in_dir(in_dir), .in_width(in_width), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_oob_mask(out_oob_mask), .out_oob(out_oob),
    .clr_count(clr_count), .oob_count(oob_count)
  );

  sel_range_unit #(.DATA_W(DATA_W), .OUT_W(OUT_W), .IDX_W(IDX_W), .FILL(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .in_index(in_index), .in_dir(in_dir), .in_width(in_width), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_oob_mask(out_oob_mask2), .out_oob(out_oob2),
    .clr_count(clr_count), .oob_count(oob_count2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] m;
    logic       o;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_c8 = 0;
  int   exp_c2 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare presented output against the queue head; pop on handshake.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data %0h mask %0h expected none", out_data, out_oob_mask);
      end else begin
        chk("result", {15'd0, out_data, out_oob_mask, out_oob}, {15'd0, q[0].d, q[0].m, q[0].o});
        if (out_ready) begin
          if (q[0].o) begin
            exp_c8 = (exp_c8 == 255) ? 255 : exp_c8 + 1;
            exp_c2 = (exp_c2 == 3) ? 3 : exp_c2 + 1;
          end
          void'(q.pop_front());
        end
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [DATA_W-1:0] d, input int idx, input logic dir, input int w,
                      input logic [7:0] ed, input logic [7:0] em);
    exp_t e;
    int   n;
    in_data  = d;
    in_index = IDX_W'(idx);
    in_dir   = dir;
    in_width = WW'(w);
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
      @(posedge clk);
      #1 in_valid = 1'b0;
    end else begin
      @(posedge clk);
      e.d = ed;
      e.m = em;
      e.o = |em;
      q.push_back(e);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts();
    chk("oob_count", 32'(oob_count), 32'(exp_c8));
    chk("oob_count_cnt2", 32'(oob_count2), 32'(exp_c2));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_data", 32'(out_data), 0);
    chk("reset_mask", 32'(out_oob_mask), 0);
    chk("reset_oob", 32'(out_oob), 0);
    chk("reset_in_ready", 32'(in_ready), 1);
    chk_counts();
    @(posedge clk);
    #1;

    // Top in-range bit, with latency check.
    send(44'h123, 43, 1'b0, 1, 8'h00, 8'h00);
    @(negedge clk);
    chk("latency_stage1", 32'(out_valid), 0);
    @(negedge clk);
    chk("latency_stage2", 32'(out_valid), 1);
    drain();

    // One past each end of the word.
    send(44'h123, 44, 1'b0, 1, 8'h00, 8'h01);
    send(44'h123, -1, 1'b0, 1, 8'h00, 8'h01);
    drain();
    chk_counts();
    chk("oob_count_two", 32'(oob_count), 2);

    // Down-direction windows sliding off the low end.
    send(44'h555_5555_5555, 1, 1'b1, 2, 8'h01, 8'h00);
    send(44'h555_5555_5555, 0, 1'b1, 2, 8'h02, 8'h01);
    send(44'h555_5555_5555, -1, 1'b1, 2, 8'h00, 8'h03);
    send(44'hF00_0000_0000, 40, 1'b0, 8, 8'h0F, 8'hF0);
    drain();
    chk_counts();
    chk("cnt2_saturated", 32'(oob_count2), 3);

    // Widths, clamping and extreme indices.
    send(44'h123, 0, 1'b0, 8, 8'h23, 8'h00);
    send(44'h123, 5, 1'b0, 0, 8'h00, 8'h00);
    send(44'h123, 0, 1'b0, 12, 8'h23, 8'h00);
    send(44'h123, 63, 1'b0, 8, 8'h00, 8'hFF);
    send(44'h123, -64, 1'b1, 8, 8'h00, 8'hFF);
    drain();
    chk_counts();

    // Back-to-back with a 3-cycle output stall mid-stream.
    fork
      begin
        send(44'h123, 5, 1'b0, 4, 8'h09, 8'h00);
        send(44'h123, 7, 1'b1, 8, 8'h23, 8'h00);
        send(44'hF00_0000_0000, 43, 1'b1, 3, 8'h07, 8'h00);
        send(44'hF00_0000_0000, 40, 1'b0, 8, 8'h0F, 8'hF0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("in_ready_stall", 32'(in_ready), 0);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk_counts();

    // Reset with both stages occupied.
    out_ready = 1'b0;
    send(44'h123, -1, 1'b0, 1, 8'h00, 8'h01);
    send(44'h123, 43, 1'b0, 1, 8'h00, 8'h00);
    @(negedge clk);
    chk("full_before_reset", 32'(out_valid), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
    exp_c8 = 0;
    exp_c2 = 0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_reset_out_valid", 32'(out_valid), 0);
    chk("post_reset_in_ready", 32'(in_ready), 1);
    chk_counts();
    @(negedge clk);
    chk("post_reset_no_ghost", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    send(44'h555_5555_5555, 0, 1'b1, 2, 8'h02, 8'h01);
    drain();
    chk_counts();
    chk("post_reset_count", 32'(oob_count), 1);

    // Clear coinciding with an OOB handshake.
    send(44'h123, 44, 1'b0, 1, 8'h00, 8'h01);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("clr_out_valid", 32'(out_valid), 1);
    clr_count = 1'b1;
    @(posedge clk);
    #1 clr_count = 1'b0;
    exp_c8 = 0;
    exp_c2 = 0;
    chk("clr_wins", 32'(oob_count), 0);
    chk("clr_wins_cnt2", 32'(oob_count2), 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
